triangle_fifo_reader: RTL and testbench



---
 rtl/triangle_fifo_reader_if.sv | 30 +++
 rtl/triangle_fifo_reader.sv | 150 +++++++++++++++
 tb/tb_triangle_fifo_reader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/triangle_fifo_reader_if.sv
// Read-side bundle between the TriangleFIFO and CalcLine: FIFO read port plus the
// valid/ready record stream. The reader takes the master view, the environment the slave.
interface triangle_fifo_reader_if #(
    parameter int DATA_W = 224
);
    logic [DATA_W-1:0] TriangleFIFO_ReadData;
    logic              TriangleFIFO_empty;
    logic              TriangleFIFO_pop;
    logic [DATA_W-1:0] TriangleFIFO_CalcLine_Data;
    logic              TriangleFIFO_CalcLine_valid;
    logic              CalcLine_TriangleFIFO_ready;

    modport master (
        input  TriangleFIFO_ReadData,
        input  TriangleFIFO_empty,
        output TriangleFIFO_pop,
        output TriangleFIFO_CalcLine_Data,
        output TriangleFIFO_CalcLine_valid,
        input  CalcLine_TriangleFIFO_ready
    );

    modport slave (
        output TriangleFIFO_ReadData,
        output TriangleFIFO_empty,
        input  TriangleFIFO_pop,
        input  TriangleFIFO_CalcLine_Data,
        input  TriangleFIFO_CalcLine_valid,
        output CalcLine_TriangleFIFO_ready
    );
endinterface

// File: rtl/triangle_fifo_reader.sv
// TriangleFIFO read controller: pops records, hides the FIFO read latency behind a
// 2-entry skid buffer and streams records to CalcLine, with frame flush and dispatch count.
module triangle_fifo_reader #(
    parameter int DATA_W       = 224,
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic                   clk100,
    input  logic                   rst_n,
    input  logic                   nextFrame,
    triangle_fifo_reader_if.master fifoBus,
    output logic [CNT_W-1:0]       Dispatch_count
);
    localparam int IW = $clog2(READ_LATENCY + 1);

    logic [1:0]        occReg;
    logic [1:0]        occNext;
    logic [DATA_W-1:0] bufReg [2];
    logic [DATA_W-1:0] bufNext [2];
    logic              flightReg [READ_LATENCY];
    logic [IW-1:0]     discardReg;
    logic [IW-1:0]     discardNext;
    logic [CNT_W-1:0]  countReg;
    logic [CNT_W-1:0]  countNext;

    logic              headValid;
    logic [DATA_W-1:0] headData;
    logic              transfer;
    logic              popComb;
    logic              retBit;
    logic              retLive;
    logic [IW-1:0]     inflightCnt;
    logic [IW-1:0]     liveInflight;
    logic [3:0]        commitment;
    logic [1:0]        wrIdx;

    assign headValid = (occReg != 2'd0);
    assign headData  = bufReg[0];
    assign transfer  = headValid && fifoBus.CalcLine_TriangleFIFO_ready;
    assign retBit    = flightReg[READ_LATENCY-1];
    // A returning beat owed to a flushed frame is swallowed while the discard count is non-zero.
    assign retLive   = retBit && (discardReg == '0);
    assign wrIdx     = occReg - 2'(transfer);

    always_comb begin
        inflightCnt = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflightCnt = inflightCnt + IW'(flightReg[i]);
        end
    end

    assign liveInflight = inflightCnt - discardReg;
    assign commitment   = 4'(occReg) + 4'(liveInflight) - 4'(transfer);

    // Only pop when the buffer can absorb every live beat still on its way back.
    always_comb begin
        popComb = 1'b0;
        if (rst_n && !nextFrame && !fifoBus.TriangleFIFO_empty && (commitment < 4'd2)) begin
            popComb = 1'b1;
        end
    end

    always_comb begin
        occNext     = occReg;
        bufNext     = bufReg;
        countNext   = countReg;
        discardNext = discardReg;
        if (nextFrame) begin
            occNext     = 2'd0;
            bufNext[0]  = '0;
            bufNext[1]  = '0;
            countNext   = '0;
            // Everything still travelling after this edge belongs to the dropped frame.
            discardNext = inflightCnt - IW'(retBit);
        end else begin
            occNext = occReg + 2'(retLive) - 2'(transfer);
            if (transfer) begin
                bufNext[0] = bufReg[1];
                if (countReg != '1) begin
                    countNext = countReg + CNT_W'(1);
                end
            end
            if (retLive) begin
                bufNext[wrIdx[0]] = fifoBus.TriangleFIFO_ReadData;
            end
            if (retBit && (discardReg != '0)) begin
                discardNext = discardReg - IW'(1);
            end
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            occReg     <= 2'd0;
            discardReg <= '0;
            countReg   <= '0;
        end else begin
            occReg     <= occNext;
            discardReg <= discardNext;
            countReg   <= countNext;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gBuf
            always_ff @(posedge clk100 or negedge rst_n) begin
                if (!rst_n) begin
                    bufReg[gi] <= '0;
                end else begin
                    bufReg[gi] <= bufNext[gi];
                end
            end
        end

        // One bit per pop in flight; the last stage lines up with ReadData being valid.
        for (gi = 0; gi < READ_LATENCY; gi++) begin : gFlight
            if (gi == 0) begin : gHead
                always_ff @(posedge clk100 or negedge rst_n) begin
                    if (!rst_n) begin
                        flightReg[gi] <= 1'b0;
                    end else begin
                        flightReg[gi] <= popComb;
                    end
                end
            end else begin : gTail
                always_ff @(posedge clk100 or negedge rst_n) begin
                    if (!rst_n) begin
                        flightReg[gi] <= 1'b0;
                    end else begin
                        flightReg[gi] <= flightReg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign fifoBus.TriangleFIFO_pop            = popComb;
    assign fifoBus.TriangleFIFO_CalcLine_valid = headValid;
    assign fifoBus.TriangleFIFO_CalcLine_Data  = headData;
    assign Dispatch_count                      = countReg;

    holdStable: assert property (@(posedge clk100) disable iff (!rst_n)
        (headValid && !fifoBus.CalcLine_TriangleFIFO_ready && !nextFrame)
            |=> (headValid && $stable(headData)));

    occBound: assert property (@(posedge clk100) disable iff (!rst_n)
        occNext <= 2'd2);

endmodule

// File: tb/tb_triangle_fifo_reader.sv
// Bench for triangle_fifo_reader: three instances (latency 1, latency 3, 4-bit counter)
// each fed by a small FIFO model with a configurable read delay.
module tb_triangle_fifo_reader;
    typedef struct {
        logic        ready;
        logic        pop;
        logic        valid;
        logic [31:0] data;
        int          count;
    } vec_t;

    logic clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    logic        rst_n;
    logic        nf1, nf3, nfS;
    logic [15:0] cnt1, cnt3;
    logic [3:0]  cntS;

    triangle_fifo_reader_if #(.DATA_W(224)) bus1();
    triangle_fifo_reader_if #(.DATA_W(224)) bus3();
    triangle_fifo_reader_if #(.DATA_W(224)) busS();

    triangle_fifo_reader #(.DATA_W(224), .READ_LATENCY(1), .CNT_W(16)) dut1 (
        .clk100(clk100), .rst_n(rst_n), .nextFrame(nf1), .fifoBus(bus1), .Dispatch_count(cnt1));
    triangle_fifo_reader #(.DATA_W(224), .READ_LATENCY(3), .CNT_W(16)) dut3 (
        .clk100(clk100), .rst_n(rst_n), .nextFrame(nf3), .fifoBus(bus3), .Dispatch_count(cnt3));
    triangle_fifo_reader #(.DATA_W(224), .READ_LATENCY(1), .CNT_W(4)) dutS (
        .clk100(clk100), .rst_n(rst_n), .nextFrame(nfS), .fifoBus(busS), .Dispatch_count(cntS));

    // FIFO models: storage, pointers and a 3-stage read pipe per instance.
    logic [31:0] mem [3][64];
    int          headIdx [3] = '{0, 0, 0};
    int          tailIdx [3] = '{0, 0, 0};
    logic [31:0] pipe [3][3];
    logic        popV [3];

    assign popV[0] = bus1.TriangleFIFO_pop;
    assign popV[1] = bus3.TriangleFIFO_pop;
    assign popV[2] = busS.TriangleFIFO_pop;

    for (genvar gi = 0; gi < 3; gi++) begin : gModel
        always @(posedge clk100) begin
            pipe[gi][1] <= pipe[gi][0];
            pipe[gi][2] <= pipe[gi][1];
            if (popV[gi]) begin
                pipe[gi][0]  <= mem[gi][headIdx[gi] % 64];
                headIdx[gi]  <= headIdx[gi] + 1;
            end else begin
                pipe[gi][0]  <= 32'hBAD0_0000 + gi;
            end
        end
    end

    assign bus1.TriangleFIFO_empty    = (headIdx[0] == tailIdx[0]);
    assign bus3.TriangleFIFO_empty    = (headIdx[1] == tailIdx[1]);
    assign busS.TriangleFIFO_empty    = (headIdx[2] == tailIdx[2]);
    assign bus1.TriangleFIFO_ReadData = 224'(pipe[0][0]);
    assign bus3.TriangleFIFO_ReadData = 224'(pipe[1][2]);
    assign busS.TriangleFIFO_ReadData = 224'(pipe[2][0]);

    int   passCount  = 0;
    int   checkCount = 0;
    vec_t vecs [31];

    task automatic check(input string name, input logic [223:0] actual, input logic [223:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("FAIL %s: actual %0h required %0h", name, actual, expected);
    endtask

    task automatic nextCycle();
        @(posedge clk100);
        #1;
    endtask

    task automatic load(input int inst, input logic [31:0] val);
        mem[inst][tailIdx[inst] % 64] = val;
        tailIdx[inst]++;
    endtask

    function automatic vec_t mk(input logic r, input logic p, input logic v, input logic [31:0] d, input int c);
        vec_t t;
        t.ready = r; t.pop = p; t.valid = v; t.data = d; t.count = c;
        return t;
    endfunction

    task automatic runRange(input string tag, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            bus1.CalcLine_TriangleFIFO_ready = vecs[k].ready;
            #2;
            $display("%s[%0d] ready=%0b pop=%0b valid=%0b data=%0h count=%0d", tag, k - first,
                     vecs[k].ready, bus1.TriangleFIFO_pop, bus1.TriangleFIFO_CalcLine_valid,
                     bus1.TriangleFIFO_CalcLine_Data, cnt1);
            check($sformatf("%s[%0d].pop", tag, k - first), 224'(bus1.TriangleFIFO_pop), 224'(vecs[k].pop));
            check($sformatf("%s[%0d].valid", tag, k - first), 224'(bus1.TriangleFIFO_CalcLine_valid), 224'(vecs[k].valid));
            check($sformatf("%s[%0d].count", tag, k - first), 224'(cnt1), 224'(vecs[k].count));
            if (vecs[k].valid)
                check($sformatf("%s[%0d].data", tag, k - first), bus1.TriangleFIFO_CalcLine_Data, 224'(vecs[k].data));
            nextCycle();
        end
    endtask

    initial begin
        rst_n = 1'b0; nf1 = 1'b0; nf3 = 1'b0; nfS = 1'b0;
        bus1.CalcLine_TriangleFIFO_ready = 1'b0;
        bus3.CalcLine_TriangleFIFO_ready = 1'b0;
        busS.CalcLine_TriangleFIFO_ready = 1'b0;

        // Streaming, latency 1, ready held high
        vecs[0]  = mk(1, 1, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 0);
        vecs[2]  = mk(1, 1, 1, 1, 0);
        vecs[3]  = mk(1, 1, 1, 2, 1);
        vecs[4]  = mk(1, 1, 1, 3, 2);
        vecs[5]  = mk(1, 1, 1, 4, 3);
        vecs[6]  = mk(1, 1, 1, 5, 4);
        vecs[7]  = mk(1, 1, 1, 6, 5);
        vecs[8]  = mk(1, 0, 1, 7, 6);
        vecs[9]  = mk(1, 0, 1, 8, 7);
        vecs[10] = mk(1, 0, 0, 0, 8);
        // Backpressure, ready high every third cycle, records 0x101..0x106
        vecs[11] = mk(1, 1, 0, 0, 0);
        vecs[12] = mk(0, 1, 0, 0, 0);
        vecs[13] = mk(0, 0, 1, 32'h101, 0);
        vecs[14] = mk(1, 1, 1, 32'h101, 0);
        vecs[15] = mk(0, 0, 1, 32'h102, 1);
        vecs[16] = mk(0, 0, 1, 32'h102, 1);
        vecs[17] = mk(1, 1, 1, 32'h102, 1);
        vecs[18] = mk(0, 0, 1, 32'h103, 2);
        vecs[19] = mk(0, 0, 1, 32'h103, 2);
        vecs[20] = mk(1, 1, 1, 32'h103, 2);
        vecs[21] = mk(0, 0, 1, 32'h104, 3);
        vecs[22] = mk(0, 0, 1, 32'h104, 3);
        vecs[23] = mk(1, 1, 1, 32'h104, 3);
        vecs[24] = mk(0, 0, 1, 32'h105, 4);
        vecs[25] = mk(0, 0, 1, 32'h105, 4);
        vecs[26] = mk(1, 0, 1, 32'h105, 4);
        vecs[27] = mk(0, 0, 1, 32'h106, 5);
        vecs[28] = mk(0, 0, 1, 32'h106, 5);
        vecs[29] = mk(1, 0, 1, 32'h106, 5);
        vecs[30] = mk(0, 0, 0, 0, 6);

        nextCycle();
        nextCycle();
        #2;
        check("reset.pop", 224'(bus1.TriangleFIFO_pop), 224'(0));
        check("reset.valid", 224'(bus1.TriangleFIFO_CalcLine_valid), 224'(0));
        check("reset.data", bus1.TriangleFIFO_CalcLine_Data, 224'(0));
        check("reset.count", 224'(cnt1), 224'(0));
        rst_n = 1'b1;
        nextCycle();

        for (int i = 1; i <= 8; i++) load(0, 32'(i));
        runRange("stream", 0, 10);

        // Flush with a non-empty FIFO: no pop during nextFrame, count cleared after
        for (int i = 1; i <= 6; i++) load(0, 32'h100 + 32'(i));
        nf1 = 1'b1;
        #2;
        check("flush1.pop", 224'(bus1.TriangleFIFO_pop), 224'(0));
        nextCycle();
        nf1 = 1'b0;
        #1;
        check("flush1.count", 224'(cnt1), 224'(0));
        check("flush1.valid", 224'(bus1.TriangleFIFO_CalcLine_valid), 224'(0));
        check("flush1.data", bus1.TriangleFIFO_CalcLine_Data, 224'(0));
        runRange("backpressure", 11, 30);

        // Empty boundary: one record then empty
        load(0, 32'h11);
        bus1.CalcLine_TriangleFIFO_ready = 1'b1;
        #2;
        check("empty0.pop", 224'(bus1.TriangleFIFO_pop), 224'(1));
        nextCycle(); #2;
        check("empty1.pop", 224'(bus1.TriangleFIFO_pop), 224'(0));
        check("empty1.valid", 224'(bus1.TriangleFIFO_CalcLine_valid), 224'(0));
        nextCycle(); #2;
        check("empty2.valid", 224'(bus1.TriangleFIFO_CalcLine_valid), 224'(1));
        check("empty2.data", bus1.TriangleFIFO_CalcLine_Data, 224'(32'h11));
        check("empty2.pop", 224'(bus1.TriangleFIFO_pop), 224'(0));
        nextCycle(); #2;
        check("empty3.valid", 224'(bus1.TriangleFIFO_CalcLine_valid), 224'(0));
        check("empty3.count", 224'(cnt1), 224'(7));
        check("empty3.pop", 224'(bus1.TriangleFIFO_pop), 224'(0));
        nextCycle(); #2;
        check("empty4.pop", 224'(bus1.TriangleFIFO_pop), 224'(0));
        nextCycle();

        // Async reset with two records buffered
        bus1.CalcLine_TriangleFIFO_ready = 1'b0;
        for (int i = 1; i <= 4; i++) load(0, 32'h20 + 32'(i));
        #2;
        check("arst0.pop", 224'(bus1.TriangleFIFO_pop), 224'(1));
        nextCycle(); #2;
        check("arst1.pop", 224'(bus1.TriangleFIFO_pop), 224'(1));
        nextCycle(); #2;
        check("arst2.pop", 224'(bus1.TriangleFIFO_pop), 224'(0));
        nextCycle(); #2;
        check("arst3.valid", 224'(bus1.TriangleFIFO_CalcLine_valid), 224'(1));
        check("arst3.data", bus1.TriangleFIFO_CalcLine_Data, 224'(32'h21));
        check("arst3.count", 224'(cnt1), 224'(7));
        rst_n = 1'b0;
        #1;
        $display("async reset asserted mid-cycle");
        check("arst.valid", 224'(bus1.TriangleFIFO_CalcLine_valid), 224'(0));
        check("arst.pop", 224'(bus1.TriangleFIFO_pop), 224'(0));
        check("arst.count", 224'(cnt1), 224'(0));
        check("arst.data", bus1.TriangleFIFO_CalcLine_Data, 224'(0));
        nextCycle(); #2;
        check("arst.hold.pop", 224'(bus1.TriangleFIFO_pop), 224'(0));
        bus1.CalcLine_TriangleFIFO_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        check("rel0.pop", 224'(bus1.TriangleFIFO_pop), 224'(1));
        nextCycle(); #2;
        check("rel1.pop", 224'(bus1.TriangleFIFO_pop), 224'(1));
        check("rel1.valid", 224'(bus1.TriangleFIFO_CalcLine_valid), 224'(0));
        nextCycle(); #2;
        check("rel2.data", bus1.TriangleFIFO_CalcLine_Data, 224'(32'h23));
        check("rel2.valid", 224'(bus1.TriangleFIFO_CalcLine_valid), 224'(1));
        check("rel2.pop", 224'(bus1.TriangleFIFO_pop), 224'(0));
        nextCycle(); #2;
        check("rel3.data", bus1.TriangleFIFO_CalcLine_Data, 224'(32'h24));
        check("rel3.count", 224'(cnt1), 224'(1));
        nextCycle(); #2;
        check("rel4.valid", 224'(bus1.TriangleFIFO_CalcLine_valid), 224'(0));
        check("rel4.count", 224'(cnt1), 224'(2));
        nextCycle();

        // Latency 3: deliver one record so the count is non-zero
        bus3.CalcLine_TriangleFIFO_ready = 1'b1;
        load(1, 32'h30);
        #2;
        check("lat3.g0.pop", 224'(bus3.TriangleFIFO_pop), 224'(1));
        for (int g = 1; g <= 3; g++) begin
            nextCycle(); #2;
            check($sformatf("lat3.g%0d.valid", g), 224'(bus3.TriangleFIFO_CalcLine_valid), 224'(0));
        end
        nextCycle(); #2;
        check("lat3.g4.valid", 224'(bus3.TriangleFIFO_CalcLine_valid), 224'(1));
        check("lat3.g4.data", bus3.TriangleFIFO_CalcLine_Data, 224'(32'h30));
        nextCycle(); #2;
        check("lat3.g5.count", 224'(cnt3), 224'(1));
        nextCycle();

        // Flush with two reads in flight
        load(1, 32'h31);
        load(1, 32'h32);
        #2;
        check("fl.f0.pop", 224'(bus3.TriangleFIFO_pop), 224'(1));
        nextCycle(); #2;
        check("fl.f1.pop", 224'(bus3.TriangleFIFO_pop), 224'(1));
        nextCycle();
        nf3 = 1'b1;
        #2;
        check("fl.f2.pop", 224'(bus3.TriangleFIFO_pop), 224'(0));
        nextCycle();
        nf3 = 1'b0;
        load(1, 32'hAA);
        #2;
        check("fl.f3.valid", 224'(bus3.TriangleFIFO_CalcLine_valid), 224'(0));
        check("fl.f3.count", 224'(cnt3), 224'(0));
        check("fl.f3.data", bus3.TriangleFIFO_CalcLine_Data, 224'(0));
        check("fl.f3.pop", 224'(bus3.TriangleFIFO_pop), 224'(1));
        for (int f = 4; f <= 6; f++) begin
            nextCycle(); #2;
            check($sformatf("fl.f%0d.valid", f), 224'(bus3.TriangleFIFO_CalcLine_valid), 224'(0));
        end
        nextCycle(); #2;
        check("fl.f7.valid", 224'(bus3.TriangleFIFO_CalcLine_valid), 224'(1));
        check("fl.f7.data", bus3.TriangleFIFO_CalcLine_Data, 224'(32'hAA));
        check("fl.f7.count", 224'(cnt3), 224'(0));
        nextCycle(); #2;
        check("fl.f8.valid", 224'(bus3.TriangleFIFO_CalcLine_valid), 224'(0));
        check("fl.f8.count", 224'(cnt3), 224'(1));
        nextCycle();

        // Saturation: 20 records through a 4-bit counter
        for (int i = 1; i <= 20; i++) load(2, 32'h1000 + 32'(i));
        busS.CalcLine_TriangleFIFO_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            int  expCount;
            logic expValid;
            expValid = (k >= 2) && (k <= 21);
            expCount = (k < 2) ? 0 : ((k - 2) > 15 ? 15 : (k - 2));
            #2;
            $display("sat[%0d] pop=%0b valid=%0b data=%0h count=%0d", k, busS.TriangleFIFO_pop,
                     busS.TriangleFIFO_CalcLine_valid, busS.TriangleFIFO_CalcLine_Data, cntS);
            check($sformatf("sat[%0d].pop", k), 224'(busS.TriangleFIFO_pop), 224'(k < 20));
            check($sformatf("sat[%0d].valid", k), 224'(busS.TriangleFIFO_CalcLine_valid), 224'(expValid));
            check($sformatf("sat[%0d].count", k), 224'(cntS), 224'(expCount));
            if (expValid)
                check($sformatf("sat[%0d].data", k), busS.TriangleFIFO_CalcLine_Data, 224'(32'h1000 + 32'(k - 1)));
            nextCycle();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
